credit_bp_tx: RTL
=================

# credit_bp_tx

Credit-based backpressure transmitter that drains a FWFT `fifo32` (RLATENCY=0) and drives one NoC link toward a downstream `credit_bp_rx`. It pops the FIFO only when the receiver has advertised buffer space, and registers each flit onto the link. It tracks credits returned by the receiver, and flags credit-protocol violations.

## Interface
- `WIDTH`, 32: flit data width; must equal the upstream `fifo32` WIDTH.
- `CREDITS`, 127: initial and maximum credit count; equals the receiver buffer depth (DEPTH32*32-1 for a 4-deep `fifo32`).
- `CW`, $clog2(CREDITS+1): credit counter width (derived; do not override).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `i_en`  in  1  transmit enable; when low, no pops are issued and in-flight state is held.
- `i_empty`  in  1  upstream FIFO empty.
- `i_rdata`  in  WIDTH  upstream FIFO head data (valid when `i_empty`=0).
- `o_pop`  out  1  pop strobe to upstream FIFO (combinational).
- `o_valid`  out  1  link flit valid (registered).
- `o_data`  out  WIDTH  link flit data (registered).
- `i_credit`  in  1  one-cycle credit-return pulse from receiver; one pulse returns one slot.
- `o_credits`  out  CW  current credit count (registered).
- `o_sent`  out  32  count of flits sent, wraps modulo 2^32.
- `o_err`  out  1  sticky credit-overflow error.

## Operation
- `o_pop` = `i_en` & !`i_empty` & (`o_credits` != 0) & !`o_err`. It depends on registered credits only, never on `i_credit`.
- On a pop:
  - `o_data` <= `i_rdata`, `o_valid` <= 1, `o_sent` <= `o_sent`+1.
  - On a cycle without a pop, `o_valid` <= 0 and `o_data` holds its previous value.
- Credit update: next = `o_credits` - pop + `i_credit`.
  - A simultaneous pop and credit leaves the count unchanged.
- Overflow: `i_credit`=1 with no pop while `o_credits`==CREDITS is a protocol error.
  - The count holds at CREDITS and `o_err` <= 1.
  - `o_err` clears only on reset. While `o_err`=1, all popping stops.
- Underflow is impossible by construction: no pop is issued at 0 credits.
- States (implicit, decoded from the counter):
  - SEND when credits>0.
  - STALL when credits==0.
  - ERR when `o_err`=1; ERR is terminal until reset.
- Deasserting `i_en` does not suppress credit returns; credits continue to accumulate.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - `o_valid`=0, `o_data`=0, `o_credits`=CREDITS, `o_sent`=0, `o_err`=0.
  - `o_pop`=0 while in reset.
- Latency: the flit appears on the link one cycle after the pop cycle (pop at edge N gives `o_valid` high during cycle N+1).
- Throughput: one flit per cycle while credits>0 and the FIFO is non-empty.
- Credit turnaround: an `i_credit` pulse arriving at 0 credits allows a pop in the next cycle, not the same cycle.
- Reset mid-operation:
  - `o_valid` drops immediately and no pop is issued.
  - Flits already popped from the FIFO but not yet delivered are lost; the system resets both ends together.
- `i_rdata` is sampled only in cycles where `o_pop`=1.

## Structure
- Shared package `credit_bp_pkg`:
  - `DEFAULT_CREDITS` (=127).
  - `credit_t` typedef, sized via $clog2(DEFAULT_CREDITS+1).
  - Reused by `credit_bp_rx`.
- One sub-module, `credit_counter`: the up/down saturating counter with overflow detect.
  - Parameterised by MAX.
  - Inputs: dec, inc. Outputs: count, zero, ovf.
- Top level contains the pop logic, the link output registers and `o_sent`.

## Test plan
- Reset, then idle with `i_empty`=1 for 4 cycles -> `o_pop`=0, `o_valid`=0, `o_credits`=127, `o_sent`=0, `o_err`=0.
- Push 3 words (0x11111111, 0x22222222, 0x33333333) into the FIFO with no credit returns:
  - Pops occur on 3 consecutive cycles.
  - `o_data` shows the same 3 words in order, each one cycle after its pop.
  - `o_credits`=124, `o_sent`=3.
- Credit exhaustion: with no returns, push 130 words (value ii*123):
  - Exactly 127 flits are sent, then `o_pop`=0 with `o_credits`=0 and 3 words remain in the FIFO.
  - Pulse `i_credit` once: exactly one more pop occurs on the following cycle, carrying data 127*123, and `o_credits` returns to 0.
- Simultaneous pop and `i_credit` for 10 cycles at `o_credits`=50 -> 10 flits sent, `o_credits` stays 50.
- Overflow: at `o_credits`=127 with the FIFO empty, pulse `i_credit` -> `o_err`=1 next cycle, `o_credits`=127; a subsequent push produces no pop.
- Async reset mid-burst: assert `rst_n`=0 between clock edges while streaming -> `o_valid`=0 before the next edge; after release, `o_credits`=127 and `o_err`=0.

Source files
------------

// File: rtl/credit_bp_pkg.sv
// Shared definitions for the credit-based backpressure link (tx and rx sides).
package credit_bp_pkg;

    // Receiver buffer depth in flits; also the transmitter's initial credit count.
    localparam int DEFAULT_CREDITS = 127;
    localparam int CREDIT_W        = $clog2(DEFAULT_CREDITS + 1);

    typedef logic [CREDIT_W-1:0] credit_t;

    // Transmitter condition, decoded from the credit counter and the error flag.
    typedef enum logic [1:0] {
        ST_SEND  = 2'd0,
        ST_STALL = 2'd1,
        ST_ERR   = 2'd2
    } tx_state_t;

    // ERR dominates: once the link is in error it neither sends nor stalls.
    function automatic tx_state_t decode_state(input logic err, input logic zero);
        if (err)
            return ST_ERR;
        else if (zero)
            return ST_STALL;
        else
            return ST_SEND;
    endfunction

endpackage

// File: rtl/credit_bp_tx_counter.sv
// Up/down credit counter: resets to MAX, never goes below zero or above MAX.
// An increment without a decrement while already at MAX is flagged on ovf
// (combinational, same cycle) and the count holds.
module credit_counter #(
    parameter int MAX = 127,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          zero,
    output logic          ovf
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] count_nxt;

    // Status flags decoded from the current (registered) count.
    always_comb begin
        zero = (count == '0);
        ovf  = inc & ~dec & (count == MAX_C);
    end

    // Next count: a simultaneous dec and inc cancel; both ends saturate.
    always_comb begin
        count_nxt = count;
        case ({dec, inc})
            2'b10:   if (!zero) count_nxt = count - 1'b1;
            2'b01:   if (!ovf)  count_nxt = count + 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Count register, full of credits out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= MAX_C;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/credit_bp_tx.sv
// Credit-based link transmitter. Drains a first-word-fall-through FIFO and
// registers one flit per pop onto the link, spending one credit per flit.
//
// Link handshake: there is no ready signal on the link. A flit is transferred
// in every cycle where o_valid=1; the receiver is guaranteed to have room
// because a pop (and therefore a flit) is only issued while o_credits>0.
// The receiver returns space as single-cycle i_credit pulses, one per slot.
// Upstream FIFO: o_pop consumes i_rdata in the same cycle (i_rdata is valid
// whenever i_empty=0).
module credit_bp_tx
    import credit_bp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CREDITS = DEFAULT_CREDITS,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_empty,
    input  logic [WIDTH-1:0] i_rdata,
    output logic             o_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_credit,
    output logic [CW-1:0]    o_credits,
    output logic [31:0]      o_sent,
    output logic             o_err,
    output tx_state_t        o_state
);

    logic cnt_zero;
    logic cnt_ovf;

    // Credit bookkeeping; the pop is the only consumer of credits.
    credit_counter #(
        .MAX (CREDITS),
        .CW  (CW)
    ) u_credit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (o_pop),
        .inc   (i_credit),
        .count (o_credits),
        .zero  (cnt_zero),
        .ovf   (cnt_ovf)
    );

    // Pop decision from registered state only, so a returning credit can
    // never enable a pop in the cycle it arrives. rst_n gates the strobe so
    // the FIFO is left untouched while reset is held.
    always_comb begin
        o_pop = rst_n & i_en & ~i_empty & ~cnt_zero & ~o_err;
    end

    // Debug view of the transmitter condition.
    always_comb begin
        o_state = decode_state(o_err, cnt_zero);
    end

    // Link output registers: valid for exactly the cycle after each pop;
    // data keeps the last flit while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= o_pop;
            if (o_pop)
                o_data <= i_rdata;
        end
    end

    // Sent-flit counter, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_sent <= '0;
        else if (o_pop)
            o_sent <= o_sent + 32'd1;
    end

    // Sticky protocol error: a credit returned while already full means the
    // two ends disagree about buffer occupancy; only reset recovers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_err <= 1'b0;
        else if (cnt_ovf)
            o_err <= 1'b1;
    end

endmodule
